// File: rtl/mac_fixnbxn_acc.sv
// -----------------------------------------------------------------------------
// mac_fixnbxn_acc
// Multi-lane fixed-point multiply-accumulate. Each valid sample carries LANES
// operand pairs; their products are summed into one lane sum, which is
// accumulated across samples framed by in_first/in_last. The accumulator
// saturates, and a sticky flag records whether any clamp happened during the
// accumulation. The finished value is reported with a one-cycle out_valid
// pulse.
//
// Pipeline: S1 input register, S2 lane products, S3 lane sum, S4 accumulator.
//
// Ports
//   clock0    in   1             sole clock, rising edge
//   aclr0     in   1             asynchronous active-high reset
//   in_valid  in   1             sample qualifier
//   in_first  in   1             sample starts a new accumulation
//   in_last   in   1             sample ends the accumulation
//   dataa     in   LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
//   datab     in   LANES*DATA_W  same packing as dataa
//   result    out  ACC_W         accumulated dot product (held between pulses)
//   out_valid out  1             one-cycle pulse, result valid
//   out_sat   out  1             a clamp occurred in the reported accumulation
// -----------------------------------------------------------------------------
module mac_fixnbxn_acc #(
   parameter int DATA_W = 8,
   parameter int LANES  = 4,
   parameter int ACC_W  = 32,
   parameter int SIGNED = 1
) (
   input  logic                    clock0,
   input  logic                    aclr0,
   input  logic                    in_valid,
   input  logic                    in_first,
   input  logic                    in_last,
   input  logic [LANES*DATA_W-1:0] dataa,
   input  logic [LANES*DATA_W-1:0] datab,
   output logic [ACC_W-1:0]        result,
   output logic                    out_valid,
   output logic                    out_sat
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int SUM_W  = PROD_W + $clog2(LANES);
   // Two guard bits: one for signed acc+sum, one more for unsigned acc+sum.
   localparam int EXT_W  = ACC_W + 2;

   // Product modulo 2^PROD_W; the true product always fits PROD_W bits in the
   // chosen signedness, so the low bits are exact.
   function automatic logic signed [PROD_W-1:0] lane_mul(
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b
   );
      logic                     sa, sb;
      logic signed [PROD_W-1:0] ea, eb;
      sa = (SIGNED != 0) & a[DATA_W-1];
      sb = (SIGNED != 0) & b[DATA_W-1];
      ea = {{DATA_W{sa}}, a};
      eb = {{DATA_W{sb}}, b};
      return ea * eb;
   endfunction

   function automatic logic signed [SUM_W-1:0] ext_prod(input logic [PROD_W-1:0] p);
      logic s;
      s = (SIGNED != 0) & p[PROD_W-1];
      return {{(SUM_W-PROD_W){s}}, p};
   endfunction

   function automatic logic signed [EXT_W-1:0] ext_sum(input logic [SUM_W-1:0] v);
      logic s;
      s = (SIGNED != 0) & v[SUM_W-1];
      return {{(EXT_W-SUM_W){s}}, v};
   endfunction

   function automatic logic signed [EXT_W-1:0] ext_acc(input logic [ACC_W-1:0] v);
      logic s;
      s = (SIGNED != 0) & v[ACC_W-1];
      return {{2{s}}, v};
   endfunction

   // Returns {clamped, value}.
   function automatic logic [ACC_W:0] saturate(input logic signed [EXT_W-1:0] t);
      logic signed [EXT_W-1:0] hi, lo;
      if (SIGNED != 0) begin
         hi = '0;
         hi[ACC_W-2:0] = '1;
         lo = '1;
         lo[ACC_W-2:0] = '0;
      end else begin
         hi = '0;
         hi[ACC_W-1:0] = '1;
         lo = '0;
      end
      if (t > hi)
         return {1'b1, hi[ACC_W-1:0]};
      else if (t < lo)
         return {1'b1, lo[ACC_W-1:0]};
      else
         return {1'b0, t[ACC_W-1:0]};
   endfunction

   // ---- S1: input register ----
   logic                    vld_p1, first_p1, last_p1;
   logic [LANES*DATA_W-1:0] a_p1, b_p1;

   // ---- S2: lane products ----
   logic                    vld_p2, first_p2, last_p2;
   logic [PROD_W-1:0]       prod_c  [LANES];
   logic [PROD_W-1:0]       prod_p2 [LANES];

   // ---- S3: lane sum ----
   logic                    vld_p3, first_p3, last_p3;
   logic signed [SUM_W-1:0] sum_c;
   logic [SUM_W-1:0]        sum_p3;

   // ---- S4: accumulator ----
   logic [ACC_W-1:0]        acc;
   logic                    sticky;
   logic signed [EXT_W-1:0] base_c, total_c;
   logic [ACC_W:0]          sat_res_c;
   logic [ACC_W-1:0]        acc_c;
   logic                    clamp_c, sticky_c;

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         prod_c[i] = lane_mul(a_p1[i*DATA_W +: DATA_W], b_p1[i*DATA_W +: DATA_W]);
      end
   end

   always_comb begin
      sum_c = '0;
      for (int i = 0; i < LANES; i++) begin
         sum_c = sum_c + ext_prod(prod_p2[i]);
      end
   end

   // A first sample restarts from zero, so it can never clamp on ACC_W >= SUM_W
   // and its sticky state is its own clamp status.
   always_comb begin
      base_c    = first_p3 ? '0 : ext_acc(acc);
      total_c   = base_c + ext_sum(sum_p3);
      sat_res_c = saturate(total_c);
      acc_c     = sat_res_c[ACC_W-1:0];
      clamp_c   = sat_res_c[ACC_W];
      sticky_c  = clamp_c | (~first_p3 & sticky);
   end

   // Datapath registers: no reset, their contents only matter under vld_pN.
   always_ff @(posedge clock0) begin
      a_p1    <= dataa;
      b_p1    <= datab;
      prod_p2 <= prod_c;
      sum_p3  <= sum_c;
   end

   always_ff @(posedge clock0 or posedge aclr0) begin
      if (aclr0) begin
         vld_p1    <= 1'b0;
         first_p1  <= 1'b0;
         last_p1   <= 1'b0;
         vld_p2    <= 1'b0;
         first_p2  <= 1'b0;
         last_p2   <= 1'b0;
         vld_p3    <= 1'b0;
         first_p3  <= 1'b0;
         last_p3   <= 1'b0;
         acc       <= '0;
         sticky    <= 1'b0;
         result    <= '0;
         out_valid <= 1'b0;
         out_sat   <= 1'b0;
      end else begin
         // ---- S1 ----
         vld_p1   <= in_valid;
         first_p1 <= in_valid & in_first;
         last_p1  <= in_valid & in_last;
         // ---- S2 ----
         vld_p2   <= vld_p1;
         first_p2 <= first_p1;
         last_p2  <= last_p1;
         // ---- S3 ----
         vld_p3   <= vld_p2;
         first_p3 <= first_p2;
         last_p3  <= last_p2;
         // ---- S4 ----
         if (vld_p3) begin
            acc    <= acc_c;
            sticky <= sticky_c;
         end
         out_valid <= vld_p3 & last_p3;
         if (vld_p3 & last_p3) begin
            result  <= acc_c;
            out_sat <= sticky_c;
         end
      end
   end

endmodule
